// File: rtl/idct8_stream.sv
// ============================================================================
//  Module   : idct8_stream
//  Brief    : Streaming 8-point inverse DCT, valid/ready in and out, with a
//             double-buffered output stage.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module idct8_stream #(
    parameter int N         = 8,
    parameter int IN_W      = 16,
    parameter int COEFF_W   = 12,
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_valid,
    input  logic signed [IN_W-1:0]  din,
    output logic                    din_ready,
    output logic                    dout_valid,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_last,
    input  logic                    dout_ready
);

    localparam int ACC_W  = IN_W + COEFF_W + 3;
    localparam int PROD_W = IN_W + COEFF_W;
    localparam int IDX_W  = $clog2(N);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N - 1);
    localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    // 1024*cos(m*pi/16) for m = 0..8; all other angles fold onto this quadrant
    function automatic logic signed [COEFF_W-1:0] cos_base(input logic [3:0] m);
        case (m)
            4'd0:    cos_base = COEFF_W'(1024);
            4'd1:    cos_base = COEFF_W'(1004);
            4'd2:    cos_base = COEFF_W'(946);
            4'd3:    cos_base = COEFF_W'(851);
            4'd4:    cos_base = COEFF_W'(724);
            4'd5:    cos_base = COEFF_W'(569);
            4'd6:    cos_base = COEFF_W'(392);
            4'd7:    cos_base = COEFF_W'(200);
            default: cos_base = '0;
        endcase
    endfunction

    function automatic logic signed [COEFF_W-1:0] cos_rom(input logic [IDX_W-1:0] k,
                                                          input logic [IDX_W-1:0] n);
        logic [6:0] p;
        logic [4:0] m;
        p = 7'({n, 1'b1}) * 7'(k);
        m = p[4:0];
        if (m > 5'd16) m = 5'd0 - m;
        if (k == '0)        cos_rom = COEFF_W'(724);
        else if (m > 5'd8)  cos_rom = -cos_base(4'(5'd16 - m));
        else                cos_rom = cos_base(m[3:0]);
    endfunction

    logic [IDX_W-1:0]        kin_q;
    logic [IDX_W-1:0]        nout_q;
    logic                    acc_full_q;
    logic                    obuf_valid_q;
    logic signed [ACC_W-1:0] acc_q  [N];
    logic signed [ACC_W-1:0] acc_d  [N];
    logic signed [OUT_W-1:0] obuf_q [N];
    logic signed [OUT_W-1:0] obuf_d [N];

    logic w_accept;
    logic w_out_hs;
    logic w_last_hs;
    logic w_xfer;

    assign w_out_hs  = obuf_valid_q && dout_ready;
    assign w_last_hs = w_out_hs && (nout_q == LAST_IDX);
    assign w_xfer    = acc_full_q && (!obuf_valid_q || w_last_hs);
    assign din_ready = !rst && (!acc_full_q || w_xfer);
    assign w_accept  = din_valid && din_ready;

    assign dout_valid = obuf_valid_q;
    assign dout       = obuf_q[nout_q];
    assign dout_last  = obuf_valid_q && (nout_q == LAST_IDX);

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic signed [COEFF_W-1:0] w_coef;
        logic signed [PROD_W-1:0]  w_prod;
        logic signed [ACC_W-1:0]   w_rnd;

        assign w_coef   = cos_rom(kin_q, IDX_W'(g));
        assign w_prod   = din * w_coef;
        // kin==0 restarts the sum so a new block never needs an explicit clear
        assign acc_d[g] = ((kin_q == '0) ? ACC_ZERO : acc_q[g]) + ACC_W'(w_prod);
        assign w_rnd    = (acc_q[g] + RND_HALF) >>> FRAC_BITS;
        assign obuf_d[g] = (w_rnd > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                           (w_rnd < SAT_MIN) ? SAT_MIN[OUT_W-1:0] :
                                               w_rnd[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kin_q        <= '0;
            nout_q       <= '0;
            acc_full_q   <= 1'b0;
            obuf_valid_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                acc_q[i]  <= '0;
                obuf_q[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                for (int i = 0; i < N; i++) acc_q[i] <= acc_d[i];
                kin_q <= (kin_q == LAST_IDX) ? '0 : kin_q + 1'b1;
            end

            if (w_accept && (kin_q == LAST_IDX)) acc_full_q <= 1'b1;
            else if (w_xfer)                     acc_full_q <= 1'b0;

            // a transfer on the last output handshake reloads with no bubble
            if (w_xfer) begin
                for (int i = 0; i < N; i++) obuf_q[i] <= obuf_d[i];
                obuf_valid_q <= 1'b1;
                nout_q       <= '0;
            end else if (w_out_hs) begin
                nout_q <= nout_q + 1'b1;
                if (nout_q == LAST_IDX) obuf_valid_q <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_idct8_stream.sv
// ============================================================================
//  Module   : tb_idct8_stream
//  Brief    : Scoreboard bench for idct8_stream against a real-valued ROM model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_idct8_stream;

    logic               clk = 1'b0;
    logic               rst;
    logic               din_valid;
    logic signed [15:0] din;
    logic               din_ready;
    logic               dout_valid;
    logic signed [15:0] dout;
    logic               dout_last;
    logic               dout_ready;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int hs_log[$];
    int rx_cnt   = 0;
    int cyc      = 0;
    bit stall_mode = 1'b0;
    int C [8][8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    idct8_stream dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_last  (dout_last),
        .dout_ready (dout_ready)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int model(input int x[8], input int n);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < 8; k++) acc += longint'(x[k]) * longint'(C[k][n]);
        r = (acc + 1024) >>> 11;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic send_coef(input int v, output int w);
        din_valid = 1'b1;
        din       = 16'(v);
        w         = 0;
        forever begin
            @(negedge clk);
            if (din_ready) break;
            w++;
            if (w > 2000) begin
                check("din_ready_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input int x[8], output int waits);
        int w;
        waits = 0;
        for (int k = 0; k < 8; k++) begin
            send_coef(x[k], w);
            waits += w;
        end
        for (int n = 0; n < 8; n++) exp_q.push_back(model(x, n));
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    task automatic pulse_reset(input string tag);
        din_valid = 1'b0;
        rst       = 1'b1;
        exp_q.delete();
        rx_cnt    = 0;
        @(negedge clk);
        check({tag, "_ready_in_rst"}, din_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, dout_valid, 0);
        check({tag, "_dout"},  int'(dout), 0);
        check({tag, "_last"},  dout_last, 0);
        check({tag, "_ready_after"}, din_ready, 1);
        @(posedge clk);
        #1;
    endtask

    function automatic void rand_block(output int x[8]);
        for (int k = 0; k < 8; k++) x[k] = int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // monitor: scoreboard pops, hold-under-stall checks
    initial begin
        bit prev_stall;
        int pd;
        int pl;
        int e;
        prev_stall = 1'b0;
        pd = 0;
        pl = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", dout_valid, 1);
                    check("hold_data", int'(dout), pd);
                    check("hold_last", dout_last, pl);
                end
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_sample", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sample", int'(dout), e);
                        check("last", dout_last, int'(rx_cnt % 8 == 7));
                    end
                    rx_cnt++;
                    hs_log.push_back(cyc);
                end
                prev_stall = dout_valid && !dout_ready;
                pd = int'(dout);
                pl = dout_last;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            dout_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int x[8];
        int w;
        int tot;
        int rx0;
        int t;
        real c;
        real pi;

        pi = 3.14159265358979;
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++) begin
                c = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
                C[k][n] = $rtoi($floor(2048.0 * c * $cos(real'((2 * n + 1) * k) * pi / 16.0) + 0.5));
            end

        rst = 1'b1; din_valid = 1'b0; din = '0; dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pulse_reset("init");

        x = '{800, 0, 0, 0, 0, 0, 0, 0};
        send_block(x, w); din_valid = 1'b0; wait_drain("dc_pos_drain");
        x = '{-800, 0, 0, 0, 0, 0, 0, 0};
        send_block(x, w); din_valid = 1'b0; wait_drain("dc_neg_drain");
        x = '{0, 1000, 0, 0, 0, 0, 0, 0};
        send_block(x, w); din_valid = 1'b0; wait_drain("ac1_drain");
        x = '{32767, 0, 32767, 0, 32767, 0, 0, 0};
        send_block(x, w); din_valid = 1'b0; wait_drain("sat_pos_drain");
        x = '{-32768, 0, -32768, 0, -32768, 0, 0, 0};
        send_block(x, w); din_valid = 1'b0; wait_drain("sat_neg_drain");

        hs_log.delete();
        tot = 0;
        for (int b = 0; b < 4; b++) begin
            rand_block(x);
            send_block(x, w);
            tot += w;
        end
        din_valid = 1'b0;
        wait_drain("b2b_drain");
        check("b2b_din_stalls", tot, 0);
        check("b2b_samples", hs_log.size(), 32);
        if (hs_log.size() >= 32) check("b2b_span", hs_log[31] - hs_log[0], 31);

        rx0 = rx_cnt;
        stall_mode = 1'b1;
        for (int b = 0; b < 6; b++) begin
            rand_block(x);
            send_block(x, w);
        end
        din_valid = 1'b0;
        wait_drain("stall_drain");
        stall_mode = 1'b0;
        @(posedge clk);
        #1;
        check("stall_samples", rx_cnt - rx0, 48);

        for (int k = 0; k < 5; k++) send_coef(100 * (k + 1), w);
        pulse_reset("rst_mid_in");
        x = '{800, 0, 0, 0, 0, 0, 0, 0};
        send_block(x, w); din_valid = 1'b0; wait_drain("post_rst_in_drain");
        check("post_rst_in_samples", rx_cnt, 8);

        send_block(x, w); din_valid = 1'b0;
        rx0 = rx_cnt;
        t = 0;
        while (rx_cnt < rx0 + 3 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("mid_out_progress", int'(rx_cnt >= rx0 + 3), 1);
        pulse_reset("rst_mid_out");
        send_block(x, w); din_valid = 1'b0; wait_drain("post_rst_out_drain");
        check("post_rst_out_samples", rx_cnt, 8);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
